// File: rtl/exception_ctrl.sv
// Exception/interrupt controller ahead of fetch: captures cause, return and fault
// addresses, redirects fetch to the handler vector and back on ERET.
module exception_ctrl #(
  parameter int unsigned   N      = 64,
  parameter logic [N-1:0]  VECTOR = 'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ExcInvOp,
  input  logic         ExcDAbort,
  input  logic         IRQ,
  input  logic         ERet,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] DAddr_E,
  output logic         EProc_F,
  output logic [N-1:0] EVAddr_F,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic [N-1:0] FAR,
  output logic         IntMasked,
  output logic         Halt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER   = 3'd1,
    HANDLER = 3'd2,
    LEAVE   = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] ESR_INVOP = 4'b0001;
  localparam logic [3:0] ESR_DABT  = 4'b0010;
  localparam logic [3:0] ESR_ERET  = 4'b0011;
  localparam logic [3:0] ESR_IRQ   = 4'b1110;

  state_t       state, state_d;
  logic         pend, pend_d;
  logic [N-1:0] elr_d, far_d;
  logic [3:0]   esr_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= 1'b0;
      ELR   <= '0;
      ESR   <= '0;
      FAR   <= '0;
    end else begin
      state <= state_d;
      pend  <= pend_d;
      ELR   <= elr_d;
      ESR   <= esr_d;
      FAR   <= far_d;
    end
  end

  always_comb begin
    state_d = state;
    pend_d  = pend;
    elr_d   = ELR;
    esr_d   = ESR;
    far_d   = FAR;
    case (state)
      IDLE: begin
        pend_d = pend | IRQ;
        if (ExcInvOp) begin
          state_d = ENTER;
          elr_d   = PC_E;
          esr_d   = ESR_INVOP;
        end else if (ExcDAbort) begin
          state_d = ENTER;
          elr_d   = PC_E;
          esr_d   = ESR_DABT;
          far_d   = DAddr_E;
        end else if (ERet) begin
          state_d = ENTER;
          elr_d   = PC_E;
          esr_d   = ESR_ERET;
        end else if (pend | IRQ) begin
          // Acknowledge clears pend, but a still-high level re-arms it.
          state_d = ENTER;
          elr_d   = PC_E + N'(4);
          esr_d   = ESR_IRQ;
          pend_d  = IRQ;
        end
      end
      ENTER: begin
        state_d = HANDLER;
        pend_d  = pend | IRQ;
      end
      HANDLER: begin
        pend_d = pend | IRQ;
        if (ExcInvOp || ExcDAbort) state_d = HALT;
        else if (ERet)             state_d = LEAVE;
      end
      LEAVE: begin
        state_d = IDLE;
        pend_d  = pend | IRQ;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign EProc_F   = (state == ENTER) || (state == LEAVE);
  assign EVAddr_F  = (state == ENTER) ? VECTOR : (state == LEAVE) ? ELR : '0;
  assign IntMasked = (state == ENTER) || (state == HANDLER) || (state == LEAVE);
  assign Halt      = (state == HALT);

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, inv, dab, irq, eret;
  logic [63:0] pc, daddr;
  logic        eproc, imask, halt;
  logic [63:0] evaddr, elr, far;
  logic [3:0]  esr;

  int n_cmp = 0;
  int n_err = 0;

  exception_ctrl #(.N(64), .VECTOR(64'hD8)) dut (
    .clk(clk), .reset(rst_n), .ExcInvOp(inv), .ExcDAbort(dab), .IRQ(irq),
    .ERet(eret), .PC_E(pc), .DAddr_E(daddr), .EProc_F(eproc),
    .EVAddr_F(evaddr), .ELR(elr), .ESR(esr), .FAR(far),
    .IntMasked(imask), .Halt(halt)
  );

  always #5 clk = ~clk;

  // Model: where we are in the exception lifecycle, plus the saved registers.
  bit          m_halted, m_in_handler, m_pend;
  int          m_redirect;          // 0 none, 1 to vector, 2 back to ELR
  logic [63:0] m_elr, m_far;
  logic [3:0]  m_esr;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_halted = 0; m_in_handler = 0; m_pend = 0; m_redirect = 0;
      m_elr = 0; m_far = 0; m_esr = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_redirect == 1) begin
      m_redirect = 0; m_in_handler = 1; m_pend = m_pend | irq;
    end else if (m_redirect == 2) begin
      m_redirect = 0; m_pend = m_pend | irq;
    end else if (m_in_handler) begin
      m_pend = m_pend | irq;
      if (inv || dab) begin
        m_halted = 1; m_in_handler = 0;
      end else if (eret) begin
        m_in_handler = 0; m_redirect = 2;
      end
    end else begin
      if (inv || dab || eret) begin
        m_redirect = 1;
        m_elr = pc;
        m_esr = inv ? 4'd1 : dab ? 4'd2 : 4'd3;
        if (!inv && dab) m_far = daddr;
        m_pend = m_pend | irq;
      end else if (m_pend || irq) begin
        m_redirect = 1;
        m_elr = pc + 64'd4;
        m_esr = 4'hE;
        m_pend = irq;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("EProc_F", 64'(eproc), 64'(m_redirect != 0));
    check("EVAddr_F", evaddr, (m_redirect == 1) ? 64'hD8 : (m_redirect == 2) ? m_elr : 64'd0);
    check("IntMasked", 64'(imask), 64'(m_redirect != 0 || m_in_handler));
    check("Halt", 64'(halt), 64'(m_halted));
    check("ELR", elr, m_elr);
    check("ESR", 64'(esr), 64'(m_esr));
    check("FAR", far, m_far);
  endtask

  task automatic idle_in();
    inv = 0; dab = 0; irq = 0; eret = 0;
  endtask

  initial begin
    rst_n = 0; idle_in(); pc = 0; daddr = 0;
    // Reset with events asserted
    inv = 1; irq = 1;
    repeat (5) tick();
    check("rst_eproc", 64'(eproc), 64'd0);
    check("rst_imask", 64'(imask), 64'd0);
    check("rst_esr", 64'(esr), 64'd0);
    check("rst_elr", elr, 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    rst_n = 1; irq = 0; pc = 64'h40;
    tick();
    check("rel_esr", 64'(esr), 64'd1);
    check("rel_elr", elr, 64'h40);
    idle_in(); tick();
    eret = 1; tick();
    check("ret_vaddr", evaddr, 64'h40);
    idle_in(); tick();
    tick();
    check("pend_discarded", 64'(eproc), 64'd0);

    // Invalid op
    inv = 1; pc = 64'h100; tick();
    check("inv_eproc", 64'(eproc), 64'd1);
    check("inv_vaddr", evaddr, 64'hD8);
    check("inv_elr", elr, 64'h100);
    check("inv_esr", 64'(esr), 64'd1);
    check("inv_imask", 64'(imask), 64'd1);
    idle_in(); tick();
    check("inv_eproc_drop", 64'(eproc), 64'd0);
    eret = 1; tick(); idle_in(); tick();

    // Data abort and return
    dab = 1; pc = 64'h200; daddr = 64'h8000; tick();
    check("dab_far", far, 64'h8000);
    check("dab_esr", 64'(esr), 64'd2);
    idle_in(); tick();
    eret = 1; tick();
    check("dab_ret_eproc", 64'(eproc), 64'd1);
    check("dab_ret_vaddr", evaddr, 64'h200);
    idle_in(); tick();
    check("dab_idle_imask", 64'(imask), 64'd0);

    // IRQ while masked is deferred until after return
    inv = 1; pc = 64'h10; tick();
    idle_in(); tick();
    irq = 1; pc = 64'h300; tick();
    check("masked_no_redirect", 64'(eproc), 64'd0);
    irq = 0; eret = 1; tick();
    eret = 0; pc = 64'h500; tick();
    check("leave_to_idle", 64'(imask), 64'd0);
    tick();
    check("irq_esr", 64'(esr), 64'hE);
    check("irq_elr", elr, 64'h504);
    idle_in(); tick(); eret = 1; tick(); idle_in(); tick();

    // Simultaneous events: invalid op wins, IRQ stays pending
    inv = 1; dab = 1; irq = 1; pc = 64'h600; daddr = 64'h9999; tick();
    check("sim_esr", 64'(esr), 64'd1);
    check("sim_far", far, 64'h8000);
    idle_in(); tick(); eret = 1; tick(); idle_in(); tick();
    tick();
    check("sim_pend_taken", 64'(esr), 64'hE);
    tick(); eret = 1; tick(); idle_in(); tick();
    eret = 1; pc = 64'h700; tick();
    check("illegal_eret_esr", 64'(esr), 64'd3);

    // Double fault
    idle_in(); tick();
    inv = 1; pc = 64'h900; tick();
    check("df_halt", 64'(halt), 64'd1);
    check("df_eproc", 64'(eproc), 64'd0);
    check("df_elr", elr, 64'h700);
    check("df_esr", 64'(esr), 64'd3);
    inv = 0; eret = 1; irq = 1; tick(); tick();
    check("df_sticky", 64'(halt), 64'd1);
    rst_n = 0; idle_in(); tick();
    check("df_reset_halt", 64'(halt), 64'd0);
    check("df_reset_imask", 64'(imask), 64'd0);
    rst_n = 1;

    // IRQ return address wraps at the top of the address space
    irq = 1; pc = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    check("wrap_elr", elr, 64'd0);
    idle_in(); tick(); eret = 1; tick(); idle_in(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 64) != 0;
      inv   = ($urandom % 16) == 0;
      dab   = ($urandom % 14) == 0;
      irq   = ($urandom % 7) == 0;
      eret  = ($urandom % 4) == 0;
      pc    = ($urandom % 8 == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16))
                                  : {32'($urandom), 32'($urandom)};
      daddr = {32'($urandom), 32'($urandom)};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
